// File: rtl/prga_fifo_if.sv
// prga_fifo_if: write/read handshake bundle shared by the FIFO and its user.
// The "slave" modport is the FIFO side, "master" is the producer/consumer side.
interface prga_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  rd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty;

  modport master (output wr, din, rd, input full, empty, dout);
  modport slave  (input wr, din, rd, output full, empty, dout);
endinterface

// File: rtl/prga_fifo_lookahead_buf.sv
// prga_fifo_lookahead_buf: one-entry prefetch stage for first-word-fall-through.
// The core's registered read port acts as the data holder; this block tracks
// whether it holds an unpopped entry and requests a new one from the core
// whenever that slot is free or being popped.
module prga_fifo_lookahead_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_empty,
  input  logic [DATA_WIDTH-1:0] core_dout,
  input  logic                  rd,
  output logic                  core_rd,
  output logic                  valid,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] dout
);
  logic valid_reg;
  logic pop;

  assign pop     = rd && valid_reg;
  assign core_rd = !core_empty && (!valid_reg || pop);
  assign valid   = valid_reg;
  assign empty   = !valid_reg;
  assign dout    = core_dout;

  // Slot is filled by a core fetch and freed by an upstream pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= core_rd || (valid_reg && !pop);
    end
  end
endmodule

// File: rtl/prga_fifo.sv
// prga_fifo: synchronous single-clock FIFO, standard or lookahead read mode.
// Optional macro PRGA_FIFO_ASSERT_EN compiles in simulation-only
// overflow/underflow messages; it never changes the synthesized logic.
module prga_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int LOOKAHEAD  = 0
) (
  input logic        clk,
  input logic        rst,
  prga_fifo_if.slave bus
);
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [DATA_WIDTH-1:0] core_dout_reg;

  logic core_empty;
  logic core_rd;
  logic core_rd_ok;
  logic full;
  logic wr_ok;

  // Extra pointer bit separates the full case from the empty case.
  assign core_empty = (wr_ptr_reg == rd_ptr_reg);
  assign core_rd_ok = core_rd && !core_empty;
  assign wr_ok      = bus.wr && !full;
  assign bus.full   = full;

  // Storage array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= bus.din;
    end
  end

  // Pointer update; both may advance in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok)      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (core_rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Registered read port: holds the last popped entry until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_dout_reg <= '0;
    end else if (core_rd_ok) begin
      core_dout_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
    end
  end

  generate
    if (LOOKAHEAD != 0) begin : g_lookahead
      logic             la_valid;
      logic [PTR_W-1:0] occupancy;

      prga_fifo_lookahead_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .core_empty (core_empty),
        .core_dout  (core_dout_reg),
        .rd         (bus.rd),
        .core_rd    (core_rd),
        .valid      (la_valid),
        .empty      (bus.empty),
        .dout       (bus.dout)
      );

      // The prefetched entry still counts toward capacity.
      assign occupancy = (wr_ptr_reg - rd_ptr_reg) + {{(PTR_W-1){1'b0}}, la_valid};
      assign full      = (occupancy == PTR_W'(DEPTH));
    end else begin : g_standard
      assign core_rd   = bus.rd;
      assign bus.empty = core_empty;
      assign bus.dout  = core_dout_reg;
      assign full      = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                         (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
    end
  endgenerate

`ifdef PRGA_FIFO_ASSERT_EN
  // Simulation-only report of requests made against a full or empty FIFO.
  always @(posedge clk) begin
    if (!rst && bus.wr && full)      $display("prga_fifo ERROR: overflow at %0t", $time);
    if (!rst && bus.rd && bus.empty) $display("prga_fifo ERROR: underflow at %0t", $time);
  end
`else
  // No overflow/underflow reporting in this build.
`endif
endmodule

// File: tb/tb_prga_fifo.sv
// tb_prga_fifo: drives a standard-mode and a lookahead-mode FIFO with the same
// stimulus and checks both against queue-based reference models every cycle.
module tb_prga_fifo;
  localparam int DW    = 16;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] din = '0;

  always #5 clk = ~clk;

  prga_fifo_if #(.DATA_WIDTH(DW)) if_s ();
  prga_fifo_if #(.DATA_WIDTH(DW)) if_l ();

  assign if_s.wr  = wr;
  assign if_s.din = din;
  assign if_s.rd  = rd;
  assign if_l.wr  = wr;
  assign if_l.din = din;
  assign if_l.rd  = rd;

  prga_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(0)) u_std (
    .clk (clk), .rst (rst), .bus (if_s)
  );
  prga_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .LOOKAHEAD(1)) u_la (
    .clk (clk), .rst (rst), .bus (if_l)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: q0 = standard FIFO, q1 = lookahead FIFO.
  int            cyc     = 0;
  bit            started = 1'b0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            w1[$];          // write cycle of each lookahead entry
  int            last_pop1 = -100;
  logic [DW-1:0] dout0_exp = '0;
  logic [DW-1:0] log0[$];
  logic [DW-1:0] log1[$];

  function automatic bit exp_empty0();
    return q0.size() == 0;
  endfunction

  // A lookahead entry shows two cycles after its write, and no earlier than
  // the cycle after its predecessor was popped.
  function automatic bit exp_empty1();
    int vis;
    if (q1.size() == 0) return 1'b1;
    vis = (w1[0] + 2 > last_pop1 + 1) ? w1[0] + 2 : last_pop1 + 1;
    return cyc < vis;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Reference model update at each rising edge from the inputs of that cycle.
  always @(posedge clk) begin
    bit e0, e1, f0, f1;
    logic [DW-1:0] v;
    e0 = exp_empty0();
    e1 = exp_empty1();
    f0 = (q0.size() == DEPTH);
    f1 = (q1.size() == DEPTH);
    if (rst) begin
      q0.delete(); q1.delete(); w1.delete();
      dout0_exp = '0;
      last_pop1 = -100;
    end else begin
      if (rd && !e0) begin
        dout0_exp = q0.pop_front();
        log0.push_back(dout0_exp);
      end
      if (wr && !f0) q0.push_back(din);
      if (rd && !e1) begin
        v = q1.pop_front();
        void'(w1.pop_front());
        log1.push_back(v);
        last_pop1 = cyc;
      end
      if (wr && !f1) begin
        q1.push_back(din);
        w1.push_back(cyc);
      end
    end
    cyc++;
    started = 1'b1;
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("std_empty", if_s.empty, exp_empty0());
      chk("std_full",  if_s.full,  q0.size() == DEPTH);
      chk("std_dout",  if_s.dout,  dout0_exp);
      chk("la_empty",  if_l.empty, exp_empty1());
      chk("la_full",   if_l.full,  q1.size() == DEPTH);
      if (!exp_empty1()) chk("la_dout", if_l.dout, q1[0]);
    end
  end

  task automatic step(bit r, bit w, logic [DW-1:0] d, bit rr);
    rst = r; wr = w; din = d; rd = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(bit random_rd);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      step(1'b0, 1'b0, '0, random_rd ? bit'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_done", DW'(q0.size() + q1.size()), '0);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [DW-1:0] order_vals [8] = '{16'h5A, 16'hF6, 16'h09, 16'hC4,
                                    16'h81, 16'hE2, 16'hA0, 16'h7A};
  logic [DW-1:0] fill_vals [DEPTH];

  initial begin
    // Reset held two cycles with wr asserted: nothing may be stored.
    step(1'b1, 1'b1, 16'hAAAA, 1'b0);
    step(1'b1, 1'b1, 16'hBBBB, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rst_std_empty", if_s.empty, 1'b1);
    chk("rst_std_full",  if_s.full,  1'b0);
    chk("rst_std_dout",  if_s.dout,  16'h0);
    chk("rst_la_empty",  if_l.empty, 1'b1);
    chk("rst_la_full",   if_l.full,  1'b0);
    chk("rst_la_dout",   if_l.dout,  16'h0);

    // Ordering with random read strobes.
    log0.delete(); log1.delete();
    foreach (order_vals[i]) step(1'b0, 1'b1, order_vals[i], 1'b0);
    chk("order_std_full", if_s.full, 1'b1);
    chk("order_la_full",  if_l.full, 1'b1);
    drain(1'b1);
    chk("order_std_count", DW'(log0.size()), 16'd8);
    chk("order_la_count",  DW'(log1.size()), 16'd8);
    for (int i = 0; i < 8 && i < log0.size() && i < log1.size(); i++) begin
      chk("order_std_val", log0[i], order_vals[i]);
      chk("order_la_val",  log1[i], order_vals[i]);
    end

    // Full boundary: dropped write, then simultaneous rd/wr at full.
    log0.delete(); log1.delete();
    for (int i = 0; i < DEPTH; i++) begin
      fill_vals[i] = DW'($urandom);
      step(1'b0, 1'b1, fill_vals[i], 1'b0);
    end
    chk("full_std", if_s.full, 1'b1);
    chk("full_la",  if_l.full, 1'b1);
    step(1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk("full_hold_std", if_s.full, 1'b1);
    step(1'b0, 1'b1, 16'hBEEF, 1'b1);
    chk("rdwr_full_std", if_s.full, 1'b0);
    chk("rdwr_full_la",  if_l.full, 1'b0);
    drain(1'b0);
    chk("full_std_count", DW'(log0.size()), DW'(DEPTH));
    chk("full_la_count",  DW'(log1.size()), DW'(DEPTH));
    for (int i = 0; i < DEPTH && i < log0.size() && i < log1.size(); i++) begin
      chk("full_std_val", log0[i], fill_vals[i]);
      chk("full_la_val",  log1[i], fill_vals[i]);
    end

    // Empty boundary and mode latency.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("empty_hold_std", if_s.empty, 1'b1);
    chk("empty_hold_la",  if_l.empty, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    chk("lat_std_empty", if_s.empty, 1'b0);
    chk("lat_la_empty",  if_l.empty, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("lat_std_dout",  if_s.dout,  16'h1234);
    chk("lat_la_empty2", if_l.empty, 1'b0);
    chk("lat_la_dout",   if_l.dout,  16'h1234);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("lat_std_empty2", if_s.empty, 1'b1);
    chk("lat_la_empty3",  if_l.empty, 1'b1);
    drain(1'b0);

    // Fill, then continuous rd+wr across pointer wrap.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b0, 1'b1, DW'($urandom), 1'b1);
    drain(1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'b0, bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)));
    drain(1'b1);

    // Mid-stream reset discards contents.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("mrst_std_empty", if_s.empty, 1'b1);
    chk("mrst_la_empty",  if_l.empty, 1'b1);
    log0.delete(); log1.delete();
    step(1'b0, 1'b1, 16'h4321, 1'b0);
    drain(1'b0);
    chk("mrst_std_count", DW'(log0.size()), 16'd1);
    chk("mrst_la_count",  DW'(log1.size()), 16'd1);
    if (log0.size() > 0) chk("mrst_std_val", log0[0], 16'h4321);
    if (log1.size() > 0) chk("mrst_la_val",  log1[0], 16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prga_fifo.md
# prga_fifo

Synchronous single-clock FIFO used as the generic buffering primitive between producer and consumer blocks. It provides a write port with a `full` flag and a read port with an `empty` flag. A compile-time parameter selects the read mode:
- **Standard mode:** data is returned one cycle after a read request.
- **Lookahead (first-word-fall-through) mode:** the head entry is always presented on `dout` while the FIFO is non-empty.

## Interface
Parameters:
- `DATA_WIDTH`, 32 — entry width in bits.
- `DEPTH_LOG2`, 9 — log2 of storage depth; capacity = 2**DEPTH_LOG2 entries.
- `LOOKAHEAD`, 0 — 0 = standard read mode; 1 = lookahead read mode.

Ports:
- `clk` input 1 — the single clock; all logic on its rising edge.
- `rst` input 1 — reset, synchronous and active-high.
- `full` output 1 — no write can be accepted this cycle.
- `wr` input 1 — write request.
- `din` input DATA_WIDTH — write data, sampled when `wr && !full`.
- `empty` output 1 — no read can be accepted this cycle.
- `rd` input 1 — read request; in lookahead mode this acknowledges (pops) the entry on `dout`.
- `dout` output DATA_WIDTH — read data.

## Operation
- **Write rule:** a write is accepted iff `wr && !full`. A write while `full` is dropped and leaves no state change.
- **Read rule:** a read is accepted iff `rd && !empty`. A read while `empty` is ignored; pointers and `dout` are unchanged.
- **Simultaneous accepted read and write:**
  - Occupancy is unchanged.
  - This is legal at any fill level, including full (the read proceeds, the write is rejected because `full` is evaluated at cycle start) and empty (the write proceeds, the read is rejected).
- **Pointers:**
  - Read and write pointers are DEPTH_LOG2+1 bits, so the FIFO distinguishes full from empty.
  - They wrap modulo 2**(DEPTH_LOG2+1).
  - The FIFO is full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- **Standard mode (`LOOKAHEAD`=0):** an accepted read at cycle N places the popped entry on `dout` at cycle N+1. `dout` then holds that value until the next accepted read.
- **Lookahead mode (`LOOKAHEAD`=1):**
  - Whenever `empty`=0, `dout` equals the oldest unread entry.
  - An accepted read removes it; the next entry appears on `dout` in the following cycle.
  - When `empty`=1, `dout` is don't-care.
- **Data order:** strictly first-in first-out. No entry is duplicated or lost across wrap-around.

## Timing
- **Reset** (`rst`=1 at a rising edge): pointers cleared, `empty`=1, `full`=0, `dout`=0. Any `rd`/`wr` during reset is ignored. Reset mid-operation discards all contents.
- **`full` and `empty`:**
  - Both are driven from registered state only, never combinationally from `wr`/`rd` of the same cycle.
  - `full` asserts the cycle after the write that fills the last slot.
  - `full` deasserts the cycle after an accepted read from a full FIFO.
- **Write-to-read latency, standard mode:** a write at cycle N clears `empty` at N+1. A read at N+1 returns the data on `dout` at N+2.
- **Write-to-read latency, lookahead mode:** a write at cycle N into an empty FIFO produces `empty`=0 with valid `dout` at N+2 (one prefetch stage). After that, back-to-back reads sustain one entry per cycle with no bubbles.
- **Throughput:** one write and one read per cycle in both modes.

## Configuration
- **`PRGA_FIFO_ASSERT_EN`:**
  - When defined, simulation-only checks are compiled in. They `$display` an error on overflow (`wr && full`) or underflow (`rd && empty`) when `rst`=0.
  - When undefined, no checks are compiled. Functional behaviour is identical in both cases, and the macro must never affect synthesized logic.

## Structure
- **Shared package:** no package is required. The pointer width DEPTH_LOG2+1 is a localparam in the module.
- **Sub-module `prga_fifo_lookahead_buf`:**
  - A natural split. The core implements the standard-mode FIFO (RAM array plus pointers).
  - When `LOOKAHEAD`=1, `prga_fifo_lookahead_buf` is generated on the read side. It is a one-entry prefetch register that reads from the core whenever it is empty or being popped, and presents `empty`/`dout` upstream.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles while `wr`=1 → after reset `empty`=1, `full`=0, `dout`=0, no entry stored.
- **Ordering:** write 0x5A, 0xF6, 0x09, 0xC4, 0x81, 0xE2, 0xA0, 0x7A back-to-back, then read with random `rd` → values emerge in the same order.
  - Standard mode: data appears one cycle after each accepted `rd`.
  - Lookahead mode: data is on `dout` before each accepted `rd`.
- **Full boundary:** write 2**DEPTH_LOG2 entries → `full`=1. A further write of 0xDEAD is dropped. Draining returns exactly 2**DEPTH_LOG2 original entries.
- **Empty boundary:** with `rd`=1 held while empty → no state change, `empty` stays 1. Write 0x1234 → `empty` falls and 0x1234 is returned per the mode latency.
- **Simultaneous rd/wr and wrap-around:** at full, assert `rd` and `wr` together → read proceeds, write rejected. Then stream 3×depth entries with `rd`=`wr`=1 continuously → order preserved across pointer wrap, occupancy constant.
- **Mid-stream reset:** load 5 entries, assert `rst` for 1 cycle → `empty`=1; the next write/read pair returns only the new value.
